instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Fetch stage placed upstream of the single-cycle CPU datapath. Owns the fetch PC and issues word
//   reads to a multi-cycle instruction memory over a req/ack handshake. Buffers the returned
//   instructions in a small FIFO and hands them to decode with valid/ready. Flushes on a
//   branch/jump/jr redirect.
// PARAMETERS
//   DEPTH     4      FIFO entries (power of 2, >=2)
//   RESET_PC  32'h0  fetch PC loaded on reset (word aligned)
// PORTS
//   clk_i          in   1   clock; all state updates on rising edge
//   rst_i          in   1   reset, asynchronous, active-high
//   redirect_i     in   1   flush queue, restart fetch at redirect_pc_i
//   redirect_pc_i  in   32  new fetch PC; bits[1:0] ignored (forced 0)
//   imem_req_o     out  1   read request to instruction memory
//   imem_addr_o    out  32  word address of request
//   imem_ack_i     in   1   read complete; imem_data_i valid this cycle
//   imem_data_i    in   32  returned instruction word
//   instr_valid_o  out  1   FIFO head valid
//   instr_o        out  32  head instruction
//   pc_o           out  32  PC of head instruction
//   pc_plus4_o     out  32  pc_o+4 (link value for jal)
//   instr_ready_i  in   1   decode consumes head this cycle
//   count_o        out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
// - Reset (asynchronous): fetch_pc=RESET_PC, state IDLE, FIFO empty.
//   All outputs 0, except imem_addr_o=RESET_PC.
// - FIFO: first-word-fall-through; entry = {instr, pc}.
//   - Pop when instr_valid_o & instr_ready_i.
//   - Push on an accepted ack. Push and pop in the same cycle are both legal.
//   - Never overflows: a request is only issued when a slot is free.
// - FSM: IDLE, REQ, DROP. imem_req_o=1 in REQ and DROP; imem_addr_o=fetch_pc (registered).
//   imem_addr_o and imem_req_o stay stable until ack.
//   - IDLE: if count_o<DEPTH -> REQ next cycle.
//   - REQ & ack & !redirect_i: push {imem_data_i, fetch_pc}; fetch_pc+=4.
//     Stay REQ if count after push/pop < DEPTH (back-to-back, 1 instr/cycle), else IDLE.
//   - REQ & redirect_i & !ack -> DROP.
//   - REQ & redirect_i & ack: response discarded -> IDLE.
//   - DROP: wait for ack, discard data, -> IDLE. redirect_i in DROP just reloads fetch_pc.
// - Redirect priority: redirect_i overrides push and pop that cycle.
//   - FIFO is emptied, and instr_valid_o=0 the next cycle.
//   - fetch_pc={redirect_pc_i[31:2],2'b00}.
//   - Takes effect at the next request; a pending request's address is not changed.
// - Latency: ack in cycle N -> instr_valid_o with that word in cycle N+1.
//   Redirect in cycle N with idle memory -> first request issued in cycle N+2.
// - Arithmetic: PC increment is mod 2^32, so 32'hFFFFFFFC+4 -> 0. pc_plus4_o wraps the same way.
// - Reset mid-transaction: state returns to IDLE at once, and the outstanding ack is ignored.
// - imem_ack_i while imem_req_o=0 is ignored.
// TESTING
// 1 Reset, ack every req cycle, ready=1: req at 0,4,8,C on consecutive cycles.
//   instr_valid_o from the cycle after the first ack; pc_o=0,4,8,C; pc_plus4_o=4,8,C,10.
// 2 ready=0, DEPTH=4, immediate acks: exactly 4 pushes, count_o=4, imem_req_o drops.
//   Raise ready for 1 cycle: count_o=3, then one new req at 0x10.
// 3 Request to 0x8, ack delayed 5 cycles, redirect_i=1 with pc 0x40 on cycle 2:
//   req/addr hold 0x8 until ack; that data is not pushed; next req addr=0x40; first pc_o=0x40.
// 4 FIFO holds 3 entries, redirect_i and instr_ready_i in the same cycle:
//   count_o=0 next cycle; no entry is delivered out of order.
// 5 redirect_pc_i=32'hFFFFFFFE: addresses 0xFFFFFFFC, then 0x0; pc_plus4_o=0 for the first word.
// 6 rst_i pulsed mid-request, during a late ack: all outputs 0 immediately;
//   after release, first req addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage ahead of the decode/execute datapath.
// Owns the fetch PC, issues word reads to a multi-cycle instruction memory
// over req/ack, and buffers returned words in a first-word-fall-through
// FIFO of {instr, pc} entries. A redirect flushes the buffer and reloads the
// fetch PC. A request already on the bus keeps its address, and its data is
// dropped when the ack arrives.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no request outstanding; issue one next cycle if a slot is free
// S_REQ  | request to addr_q outstanding; its data is pushed on ack
// S_DROP | request outstanding but redirected away; discard data on ack
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                pc_plus4_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          head_valid;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;
    logic [31:0]   pc_next_seq;

    assign head_valid          = (count_q != '0);
    assign redirect_pc_aligned = redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_next_seq         = fetch_pc_q + 32'd4;

    // Redirect overrides both queue operations in the same cycle.
    assign pop  = head_valid && instr_ready_i && !redirect_i;
    assign push = (state_q == S_REQ) && imem_ack_i && !redirect_i;

    // Occupancy after this cycle's push/pop; decides whether to keep streaming.
    assign count_after = count_q + CW'(push) - CW'(pop);

    // Next-state, fetch PC and request address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_aligned;
                end else if (count_q < FULL) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_aligned;
                    state_d    = imem_ack_i ? S_IDLE : S_DROP;
                end else if (imem_ack_i) begin
                    fetch_pc_d = pc_next_seq;
                    if (count_after < FULL) begin
                        addr_d = pc_next_seq;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_aligned;
                end
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; a redirect empties the queue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_after;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only visible when the head is valid, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_data_i;
            pc_mem[wr_ptr_q]    <= addr_q;
        end
    end

    assign imem_req_o    = (state_q != S_IDLE);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? instr_mem[rd_ptr_q] : 32'd0;
    assign pc_o          = head_valid ? pc_mem[rd_ptr_q] : 32'd0;
    assign pc_plus4_o    = head_valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;
    assign count_o       = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a
// randomized run against a transaction-level queue model.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_data_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic [31:0]   pc_plus4_o;
    logic          instr_ready_i;
    logic [CW-1:0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic apply_reset();
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'd0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; redirect_i = 0; redirect_pc_i = 0;
        imem_ack_i = 0; imem_data_i = 0; instr_ready_i = 0;
        @(negedge clk_i);
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b want=0", imem_req_o); end
        n_cmp++; if (imem_addr_o !== RESET_PC) begin n_bad++; $display("FAIL rst_addr got=%h want=%h", imem_addr_o, RESET_PC); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b want=0", instr_valid_o); end
        n_cmp++; if (instr_o !== 32'd0) begin n_bad++; $display("FAIL rst_instr got=%h want=0", instr_o); end
        n_cmp++; if (pc_o !== 32'd0) begin n_bad++; $display("FAIL rst_pc got=%h want=0", pc_o); end
        n_cmp++; if (pc_plus4_o !== 32'd0) begin n_bad++; $display("FAIL rst_pc4 got=%h want=0", pc_plus4_o); end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL rst_count got=%0d want=0", count_o); end
    endtask

    task automatic test_stream();
        logic [31:0] ra [4];
        logic [31:0] pv [4];
        logic [31:0] p4 [4];
        logic [31:0] iv [4];
        int rc [4];
        int nreq = 0;
        int nval = 0;
        int fv = -1;
        apply_reset();
        instr_ready_i = 1'b1;
        for (int c = 0; c < 30 && nval < 4; c++) begin
            @(negedge clk_i);
            if (instr_valid_o) begin
                if (fv < 0) fv = c;
                pv[nval] = pc_o; p4[nval] = pc_plus4_o; iv[nval] = instr_o;
                nval++;
            end
            if (imem_req_o) begin
                if (nreq < 4) begin ra[nreq] = imem_addr_o; rc[nreq] = c; end
                nreq++;
                imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        imem_ack_i = 1'b0; instr_ready_i = 1'b0;
        n_cmp++;
        if (nreq < 4 || nval < 4) begin
            n_bad++; $display("FAIL stream_timeout got req=%0d val=%0d want 4/4", nreq, nval);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (ra[i] !== 32'(i * 4)) begin n_bad++; $display("FAIL stream_addr%0d got=%h want=%h", i, ra[i], 32'(i * 4)); end
                n_cmp++; if (pv[i] !== 32'(i * 4)) begin n_bad++; $display("FAIL stream_pc%0d got=%h want=%h", i, pv[i], 32'(i * 4)); end
                n_cmp++; if (p4[i] !== 32'(i * 4 + 4)) begin n_bad++; $display("FAIL stream_pc4_%0d got=%h want=%h", i, p4[i], 32'(i * 4 + 4)); end
                n_cmp++; if (iv[i] !== mk(32'(i * 4))) begin n_bad++; $display("FAIL stream_instr%0d got=%h want=%h", i, iv[i], mk(32'(i * 4))); end
                if (i > 0) begin
                    n_cmp++; if (rc[i] !== rc[0] + i) begin n_bad++; $display("FAIL stream_b2b%0d got=%0d want=%0d", i, rc[i], rc[0] + i); end
                end
            end
            n_cmp++; if (fv !== rc[0] + 1) begin n_bad++; $display("FAIL stream_latency got=%0d want=%0d", fv, rc[0] + 1); end
        end
    endtask

    task automatic test_full();
        int pushes = 0;
        logic got = 1'b0;
        logic [31:0] a = 32'd0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (imem_req_o) begin
                pushes++; imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        n_cmp++; if (pushes !== 4) begin n_bad++; $display("FAIL full_pushes got=%0d want=4", pushes); end
        n_cmp++; if (count_o !== CW'(4)) begin n_bad++; $display("FAIL full_count got=%0d want=4", count_o); end
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL full_req got=%b want=0", imem_req_o); end
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        instr_ready_i = 1'b0;
        n_cmp++; if (count_o !== CW'(3)) begin n_bad++; $display("FAIL full_pop_count got=%0d want=3", count_o); end
        n_cmp++; if (pc_o !== 32'h4) begin n_bad++; $display("FAIL full_pop_head got=%h want=4", pc_o); end
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk_i);
            if (imem_req_o) begin
                got = 1'b1; a = imem_addr_o;
                imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end
        end
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        n_cmp++; if (!got || a !== 32'h10) begin n_bad++; $display("FAIL full_refill_addr got=%h seen=%b want=10", a, got); end
        n_cmp++; if (count_o !== CW'(4)) begin n_bad++; $display("FAIL full_refill_count got=%0d want=4", count_o); end
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL full_refill_req got=%b want=0", imem_req_o); end
    endtask

    // Acks every request with mk(addr) and reports the first request address and first head.
    task automatic collect_first(output logic [31:0] fa, output logic [31:0] fp,
                                 output logic [31:0] fi, output logic ok);
        logic gr = 1'b0;
        logic gv = 1'b0;
        fa = 32'hX; fp = 32'hX; fi = 32'hX;
        for (int c = 0; c < 12 && !(gr && gv); c++) begin
            @(negedge clk_i);
            if (instr_valid_o && !gv) begin gv = 1'b1; fp = pc_o; fi = instr_o; end
            if (imem_req_o) begin
                if (!gr) begin gr = 1'b1; fa = imem_addr_o; end
                imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        imem_ack_i = 1'b0;
        ok = gr && gv;
    endtask

    task automatic test_redirect_drop();
        logic seen = 1'b0;
        logic ok;
        logic [31:0] fa, fp, fi;
        apply_reset();
        instr_ready_i = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            if (imem_req_o && imem_addr_o === 32'h8) begin
                seen = 1'b1; imem_ack_i = 1'b0;
            end else if (imem_req_o) begin
                imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL drop_find8 got=none want=req@8"); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
                n_bad++; $display("FAIL drop_hold k=%0d got req=%b addr=%h want 1/8", k, imem_req_o, imem_addr_o);
            end
            if (k >= 3) begin
                n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL drop_flush k=%0d got=%b want=0", k, instr_valid_o); end
            end
            redirect_i    = (k == 2);
            redirect_pc_i = 32'h40;
            imem_ack_i    = (k == 5);
            imem_data_i   = 32'hDEAD_BEEF;
        end
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL drop_discard got=%b want=0", instr_valid_o); end
        collect_first(fa, fp, fi, ok);
        n_cmp++; if (!ok || fa !== 32'h40) begin n_bad++; $display("FAIL drop_newaddr got=%h want=40", fa); end
        n_cmp++; if (!ok || fp !== 32'h40 || fi !== mk(32'h40)) begin n_bad++; $display("FAIL drop_newhead got pc=%h instr=%h want 40/%h", fp, fi, mk(32'h40)); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_redirect_pop();
        int acked = 0;
        logic ok;
        logic [31:0] fa, fp, fi;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (imem_req_o && acked < 3) begin
                acked++; imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        n_cmp++; if (count_o !== CW'(3)) begin n_bad++; $display("FAIL rpop_fill got=%0d want=3", count_o); end
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_bad++; $display("FAIL rpop_pending got req=%b addr=%h want 1/C", imem_req_o, imem_addr_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h100; instr_ready_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0; instr_ready_i = 1'b0;
        n_cmp++; if (count_o !== '0 || instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rpop_flush got count=%0d valid=%b want 0/0", count_o, instr_valid_o); end
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_bad++; $display("FAIL rpop_hold got req=%b addr=%h want 1/C", imem_req_o, imem_addr_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'hBAD0_0BAD;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL rpop_discard got=%0d want=0", count_o); end
        instr_ready_i = 1'b1;
        collect_first(fa, fp, fi, ok);
        n_cmp++; if (!ok || fa !== 32'h100) begin n_bad++; $display("FAIL rpop_newaddr got=%h want=100", fa); end
        n_cmp++; if (!ok || fp !== 32'h100 || fi !== mk(32'h100)) begin n_bad++; $display("FAIL rpop_newhead got pc=%h instr=%h want 100/%h", fp, fi, mk(32'h100)); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; instr_ready_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL wrap_n1_req got=%b want=0", imem_req_o); end
        @(negedge clk_i);
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_n2_req got req=%b addr=%h want 1/FFFFFFFC", imem_req_o, imem_addr_o); end
        imem_ack_i = 1'b1; imem_data_i = mk(32'hFFFF_FFFC);
        @(negedge clk_i);
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
        n_cmp++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin n_bad++; $display("FAIL wrap_head got pc=%h pc4=%h want FFFFFFFC/0", pc_o, pc_plus4_o); end
        n_cmp++; if (instr_o !== mk(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr got=%h want=%h", instr_o, mk(32'hFFFF_FFFC)); end
        imem_data_i = mk(32'h0);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        n_cmp++; if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4) begin n_bad++; $display("FAIL wrap_second got pc=%h pc4=%h want 0/4", pc_o, pc_plus4_o); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acked = 0;
        logic ok;
        logic [31:0] fa, fp, fi;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (imem_req_o && acked < 2) begin
                acked++; imem_ack_i = 1'b1; imem_data_i = mk(imem_addr_o);
            end else begin
                imem_ack_i = 1'b0;
            end
        end
        imem_ack_i = 1'b1; imem_data_i = 32'h1234_5678; rst_i = 1'b1;
        #1;
        n_cmp++; if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC) begin n_bad++; $display("FAIL rmid_req got req=%b addr=%h want 0/%h", imem_req_o, imem_addr_o, RESET_PC); end
        n_cmp++; if (instr_valid_o !== 1'b0 || count_o !== '0) begin n_bad++; $display("FAIL rmid_fifo got valid=%b count=%0d want 0/0", instr_valid_o, count_o); end
        n_cmp++; if (instr_o !== 32'd0 || pc_o !== 32'd0 || pc_plus4_o !== 32'd0) begin n_bad++; $display("FAIL rmid_head got %h %h %h want 0", instr_o, pc_o, pc_plus4_o); end
        @(negedge clk_i);
        rst_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b1;
        collect_first(fa, fp, fi, ok);
        n_cmp++; if (!ok || fa !== RESET_PC) begin n_bad++; $display("FAIL rmid_addr got=%h want=%h", fa, RESET_PC); end
        n_cmp++; if (!ok || fp !== RESET_PC || fi !== mk(RESET_PC)) begin n_bad++; $display("FAIL rmid_head2 got pc=%h instr=%h want %h/%h", fp, fi, RESET_PC, mk(RESET_PC)); end
        instr_ready_i = 1'b0;
    endtask

    // Transaction-level model: the queue holds {instr,pc}; next_pc is the
    // address the next fresh request must use; a request redirected before its
    // ack is held at its old address and produces no entry.
    task automatic test_random();
        ent_t q[$];
        ent_t e;
        logic [31:0] next_pc, held, exp_a, rpc, dat;
        logic drop, rd, rdy, ak, rq;
        apply_reset();
        next_pc = RESET_PC; held = 32'd0; drop = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            n_cmp++; if (count_o !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count_o, q.size()); end
            n_cmp++; if (instr_valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, instr_valid_o, q.size() != 0); end
            if (q.size() != 0) begin
                n_cmp++; if (instr_o !== q[0].instr) begin n_bad++; $display("FAIL rnd_instr c=%0d got=%h want=%h", c, instr_o, q[0].instr); end
                n_cmp++; if (pc_o !== q[0].pc) begin n_bad++; $display("FAIL rnd_pc c=%0d got=%h want=%h", c, pc_o, q[0].pc); end
                n_cmp++; if (pc_plus4_o !== q[0].pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc4 c=%0d got=%h want=%h", c, pc_plus4_o, q[0].pc + 32'd4); end
            end
            exp_a = drop ? held : next_pc;
            if (imem_req_o) begin
                n_cmp++; if (imem_addr_o !== exp_a) begin n_bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr_o, exp_a); end
            end
            rq  = imem_req_o;
            rdy = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            ak  = rq ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            dat = $urandom;
            instr_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
            imem_ack_i = ak; imem_data_i = dat;
            if (rd) begin
                q.delete();
                next_pc = rpc & 32'hFFFF_FFFC;
                if (rq && !ak) begin held = exp_a; drop = 1'b1; end
                else if (rq && ak) drop = 1'b0;
            end else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (rq && ak) begin
                    if (drop) begin
                        drop = 1'b0;
                    end else begin
                        e.instr = dat; e.pc = next_pc;
                        q.push_back(e);
                        next_pc = next_pc + 32'd4;
                    end
                end
            end
            @(negedge clk_i);
        end
        redirect_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
